// File: rtl/cpu_control_fsm_if.sv
// Bus between the CPU controller and the RAM / register-file / ALU datapath.
// The controller sits on the master side; the datapath and RAM sit on the slave side.
interface cpu_control_fsm_if #(
  parameter int ADDR_W = 16
);
  logic [15:0]       mem_rdata;
  logic [15:0]       reg_a_data;
  logic [4:0]        flag_reg;
  logic [ADDR_W-1:0] mem_addr;
  logic              ram_we;
  logic              ram_buff_en;
  logic              alu_buff_en;
  logic [3:0]        mux_controlA;
  logic [3:0]        mux_controlB;
  logic              Imm_mux_input;
  logic [15:0]       imm;
  logic [15:0]       reg_enable;
  logic [3:0]        ALU_Op;
  logic              flag_en;
  logic              cin;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  mem_rdata, reg_a_data, flag_reg,
    output mem_addr, ram_we, ram_buff_en, alu_buff_en, mux_controlA, mux_controlB,
           Imm_mux_input, imm, reg_enable, ALU_Op, flag_en, cin, pc
  );

  modport slave (
    output mem_rdata, reg_a_data, flag_reg,
    input  mem_addr, ram_we, ram_buff_en, alu_buff_en, mux_controlA, mux_controlB,
           Imm_mux_input, imm, reg_enable, ALU_Op, flag_en, cin, pc
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU: owns PC and IR
// and drives every control input of the ALU/register-file stage.
module cpu_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ADDR_W   = 16
) (
  input logic               clk,
  input logic               reset,
  cpu_control_fsm_if.master bus
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_EXEC    = 2'd2;
  localparam logic [1:0] S_LOAD_WB = 2'd3;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_CMP = 4'b1011;

  logic [1:0]        state, state_nxt;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc_q, pc_nxt;

  logic [3:0]         op, rdest, ext, rsrc;
  logic [7:0]         imm8;
  logic signed [15:0] imm_sext;
  logic [15:0]        rdest_onehot;
  logic               is_rtype, is_immop, is_lui, is_load, is_stor, is_jcond, is_bcond, cond_true;

  function automatic logic is_alu_code(input logic [3:0] c);
    return c inside {4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101};
  endfunction

  function automatic logic is_flag_code(input logic [3:0] c);
    return c inside {4'b0101, 4'b1001, 4'b1011};
  endfunction

  // Flag register packs {C,L,F,Z,N}.
  function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] f);
    logic c, l, fl, z, n;
    {c, l, fl, z, n} = f;
    case (cond)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return l;
      4'b0101: return !l;
      4'b0110: return n;
      4'b0111: return !n;
      4'b1000: return fl;
      4'b1001: return !fl;
      4'b1010: return !l && !z;
      4'b1011: return l || z;
      4'b1100: return !n && !z;
      4'b1101: return n || z;
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    {op, rdest, ext, rsrc} = ir;
    imm8         = ir[7:0];
    imm_sext     = {{8{imm8[7]}}, imm8};
    rdest_onehot = 16'h0001 << rdest;
    is_rtype     = (op == 4'b0000) && is_alu_code(ext);
    is_lui       = (op == 4'b1111);
    is_immop     = is_alu_code(op) || is_lui;
    is_load      = (op == 4'b0100) && (ext == 4'b0000);
    is_stor      = (op == 4'b0100) && (ext == 4'b0100);
    is_jcond     = (op == 4'b0100) && (ext == 4'b1100);
    is_bcond     = (op == 4'b1100);
    cond_true    = cond_met(rdest, bus.flag_reg);
  end

  // Control outputs are a pure function of state and IR; only EXEC/LOAD_WB drive anything.
  always_comb begin
    bus.mem_addr      = pc_q;
    bus.ram_we        = 1'b0;
    bus.ram_buff_en   = 1'b0;
    bus.alu_buff_en   = 1'b0;
    bus.mux_controlA  = 4'd0;
    bus.mux_controlB  = 4'd0;
    bus.Imm_mux_input = 1'b0;
    bus.imm           = 16'h0000;
    bus.reg_enable    = 16'h0000;
    bus.ALU_Op        = 4'd0;
    bus.flag_en       = 1'b0;
    bus.cin           = 1'b0;
    bus.pc            = pc_q;
    case (state)
      S_EXEC: begin
        bus.mux_controlA = rdest;
        bus.mux_controlB = rsrc;
        if (is_rtype) begin
          bus.ALU_Op      = ext;
          bus.alu_buff_en = 1'b1;
          bus.reg_enable  = (ext == OP_CMP) ? 16'h0000 : rdest_onehot;
          bus.flag_en     = is_flag_code(ext);
        end else if (is_immop) begin
          bus.Imm_mux_input = 1'b1;
          bus.alu_buff_en   = 1'b1;
          bus.ALU_Op        = is_lui ? OP_MOV : op;
          if (is_lui)                bus.imm = {imm8, 8'h00};
          else if (is_flag_code(op)) bus.imm = imm_sext;
          else                       bus.imm = {8'h00, imm8};
          bus.reg_enable = (op == OP_CMP) ? 16'h0000 : rdest_onehot;
          bus.flag_en    = is_flag_code(op);
        end else if (is_load) begin
          bus.mux_controlA = rsrc;
          bus.mem_addr     = bus.reg_a_data[ADDR_W-1:0];
        end else if (is_stor) begin
          bus.mux_controlA = rsrc;
          bus.mux_controlB = rdest;
          bus.ALU_Op       = OP_MOV;
          bus.alu_buff_en  = 1'b1;
          bus.mem_addr     = bus.reg_a_data[ADDR_W-1:0];
          bus.ram_we       = 1'b1;
        end else if (is_jcond) begin
          bus.mux_controlA = rsrc;
        end
      end
      S_LOAD_WB: begin
        bus.mux_controlA = rsrc;
        bus.mux_controlB = rsrc;
        bus.mem_addr     = bus.reg_a_data[ADDR_W-1:0];
        bus.ram_buff_en  = 1'b1;
        bus.reg_enable   = rdest_onehot;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_load) begin
          state_nxt = S_LOAD_WB;
        end else begin
          state_nxt = S_FETCH;
          if (is_bcond && cond_true)
            pc_nxt = pc_q + {{(ADDR_W-8){imm8[7]}}, imm8};
          else if (is_jcond && cond_true)
            pc_nxt = bus.reg_a_data[ADDR_W-1:0];
          else
            pc_nxt = pc_q + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_q + ADDR_W'(1);
      end
    endcase
  end

  // Registered RAM: instruction word is on mem_rdata during DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc_q  <= RESET_PC[ADDR_W-1:0];
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (state == S_DECODE) ir <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: an instruction-level model expands each fetched word into
// its expected per-cycle control outputs, checked every cycle on the falling edge.
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic reset;

  cpu_control_fsm_if #(.ADDR_W(16)) bus();
  cpu_control_fsm #(.RESET_PC(16'h0000), .ADDR_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] mem_addr;
    logic        ram_we;
    logic        ram_buff_en;
    logic        alu_buff_en;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic        immsel;
    logic [15:0] imm;
    logic [15:0] reg_en;
    logic [3:0]  aluop;
    logic        flag_en;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cmp_e;
  logic [15:0] ram [logic [15:0]];
  logic [15:0] mpc;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [15:0] ram_rd(input logic [15:0] a);
    return ram.exists(a) ? ram[a] : 16'h0000;
  endfunction

  always @(posedge clk) bus.mem_rdata <= ram_rd(bus.mem_addr);

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Condition truth table indexed by the 4-bit condition code; flags are {C,L,F,Z,N}.
  function automatic logic cond_ok(input logic [3:0] cc, input logic [4:0] fl);
    logic c, l, f, z, n;
    logic [15:0] t;
    {c, l, f, z, n} = fl;
    t = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f, !n, n, !l, l, !c, c, !z, z};
    return t[cc];
  endfunction

  task automatic model_instr(input logic [15:0] ins, input logic [15:0] rad, input logic [4:0] fl,
                             output int n, output logic [15:0] npc);
    exp_t e0, x, w;
    logic [3:0] op, rd, ex, rs;
    logic [7:0] i8;
    {op, rd, ex, rs} = ins;
    i8 = ins[7:0];
    e0 = '0;
    e0.mem_addr = mpc;
    e0.pc = mpc;
    exp_q.push_back(e0);
    exp_q.push_back(e0);
    x = e0;
    x.ma = rd;
    x.mb = rs;
    w = e0;
    npc = mpc + 16'd1;
    n = 3;
    if (op == 4'h0 && ex inside {4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD}) begin
      x.aluop = ex;
      x.alu_buff_en = 1'b1;
      x.reg_en = (ex == 4'hB) ? 16'h0000 : (16'h0001 << rd);
      x.flag_en = ex inside {4'h5, 4'h9, 4'hB};
    end else if (op inside {4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD, 4'hF}) begin
      x.immsel = 1'b1;
      x.alu_buff_en = 1'b1;
      if (op == 4'hF) begin
        x.aluop = 4'hD;
        x.imm = {i8, 8'h00};
      end else begin
        x.aluop = op;
        x.imm = (op inside {4'h5, 4'h9, 4'hB}) ? {{8{i8[7]}}, i8} : {8'h00, i8};
      end
      x.flag_en = op inside {4'h5, 4'h9, 4'hB};
      x.reg_en = (op == 4'hB) ? 16'h0000 : (16'h0001 << rd);
    end else if (op == 4'h4 && ex == 4'h0) begin
      x.ma = rs;
      x.mem_addr = rad;
      w = x;
      w.ram_buff_en = 1'b1;
      w.reg_en = 16'h0001 << rd;
      n = 4;
    end else if (op == 4'h4 && ex == 4'h4) begin
      x.ma = rs;
      x.mb = rd;
      x.aluop = 4'hD;
      x.alu_buff_en = 1'b1;
      x.mem_addr = rad;
      x.ram_we = 1'b1;
    end else if (op == 4'hC) begin
      if (cond_ok(rd, fl)) npc = mpc + {{8{i8[7]}}, i8};
    end else if (op == 4'h4 && ex == 4'hC) begin
      x.ma = rs;
      if (cond_ok(rd, fl)) npc = rad;
    end
    exp_q.push_back(x);
    if (n == 4) exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chk("mem_addr", bus.mem_addr, cmp_e.mem_addr);
      chk("ram_we", 16'(bus.ram_we), 16'(cmp_e.ram_we));
      chk("ram_buff_en", 16'(bus.ram_buff_en), 16'(cmp_e.ram_buff_en));
      chk("alu_buff_en", 16'(bus.alu_buff_en), 16'(cmp_e.alu_buff_en));
      chk("mux_controlA", 16'(bus.mux_controlA), 16'(cmp_e.ma));
      chk("mux_controlB", 16'(bus.mux_controlB), 16'(cmp_e.mb));
      chk("Imm_mux_input", 16'(bus.Imm_mux_input), 16'(cmp_e.immsel));
      chk("imm", bus.imm, cmp_e.imm);
      chk("reg_enable", bus.reg_enable, cmp_e.reg_en);
      chk("ALU_Op", 16'(bus.ALU_Op), 16'(cmp_e.aluop));
      chk("flag_en", 16'(bus.flag_en), 16'(cmp_e.flag_en));
      chk("cin", 16'(bus.cin), 16'h0000);
      chk("pc_cycle", bus.pc, cmp_e.pc);
    end
  end

  task automatic run(input logic [15:0] rad, input logic [4:0] fl, input logic [15:0] want_pc,
                     input int want_n, input logic pin, input logic [15:0] p_imm,
                     input logic [15:0] p_reg_en, input logic p_flag);
    int n;
    logic [15:0] npc;
    bus.reg_a_data = rad;
    bus.flag_reg = fl;
    model_instr(ram_rd(mpc), rad, fl, n, npc);
    chk("model_len", 16'(n), 16'(want_n));
    chk("model_pc", npc, want_pc);
    if (pin) begin
      chk("model_imm", exp_q[2].imm, p_imm);
      chk("model_reg_en", exp_q[exp_q.size()-1].reg_en, p_reg_en);
      chk("model_flag_en", 16'(exp_q[2].flag_en), 16'(p_flag));
    end
    repeat (n) @(posedge clk);
    #1;
    chk("pc_after", bus.pc, want_pc);
    mpc = npc;
  endtask

  initial begin
    int n;
    logic [15:0] npc;
    reset = 1'b0;
    bus.reg_a_data = 16'h0000;
    bus.flag_reg = 5'b00000;
    ram[16'h0000] = 16'h0000;
    ram[16'h0001] = 16'hD3F0;
    ram[16'h0002] = 16'h51FF;
    ram[16'h0003] = 16'h01B2;
    ram[16'h0004] = 16'h4405;
    ram[16'h0005] = 16'h4247;
    ram[16'h0006] = 16'hCE0A;
    ram[16'h0010] = 16'hC0FE;
    ram[16'h000E] = 16'hCE02;
    ram[16'h0011] = 16'h4EC6;
    ram[16'h0030] = 16'h4FC6;
    ram[16'h0031] = 16'hCA05;
    ram[16'h0036] = 16'hCD05;
    ram[16'h0037] = 16'hF912;
    ram[16'h0038] = 16'h1080;
    ram[16'h0039] = 16'h4081;
    ram[16'h003A] = 16'h4247;
    ram[16'hFFFE] = 16'h0000;
    ram[16'hFFFF] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_enables", {11'd0, bus.ram_we, bus.ram_buff_en, bus.alu_buff_en, bus.flag_en, bus.Imm_mux_input}, 16'h0000);
    chk("rst_reg_enable", bus.reg_enable, 16'h0000);
    chk("rst_sel", {bus.mux_controlA, bus.mux_controlB, bus.ALU_Op, 4'h0}, 16'h0000);
    chk("rst_imm", bus.imm, 16'h0000);
    reset = 1'b1;
    mpc = 16'h0000;

    run(16'h0000, 5'b00000, 16'h0001, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0002, 3, 1'b1, 16'h00F0, 16'h0008, 1'b0);
    run(16'h0000, 5'b00000, 16'h0003, 3, 1'b1, 16'hFFFF, 16'h0002, 1'b1);
    run(16'h0000, 5'b00000, 16'h0004, 3, 1'b1, 16'h0000, 16'h0000, 1'b1);
    run(16'h0123, 5'b00000, 16'h0005, 4, 1'b1, 16'h0000, 16'h0010, 1'b0);
    run(16'h0200, 5'b00000, 16'h0006, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0010, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00010, 16'h000E, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0010, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0011, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0030, 5'b00000, 16'h0030, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0030, 5'b00000, 16'h0031, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0036, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0037, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0038, 3, 1'b1, 16'h1200, 16'h0200, 1'b0);
    run(16'h0000, 5'b00000, 16'h0039, 3, 1'b1, 16'h0080, 16'h0001, 1'b0);
    run(16'h0000, 5'b00000, 16'h003A, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // STOR interrupted by a reset pulse in the middle of its EXEC cycle.
    bus.reg_a_data = 16'h0200;
    bus.flag_reg = 5'b00000;
    model_instr(ram_rd(mpc), 16'h0200, 5'b00000, n, npc);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_ram_we", 16'(bus.ram_we), 16'h0000);
    chk("abort_alu_buff_en", 16'(bus.alu_buff_en), 16'h0000);
    chk("abort_pc", bus.pc, 16'h0000);
    chk("abort_mem_addr", bus.mem_addr, 16'h0000);
    ram[16'h0000] = 16'hC0FE;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mpc = 16'h0000;

    run(16'h0000, 5'b00010, 16'hFFFE, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'hFFFF, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run(16'h0000, 5'b00000, 16'h0000, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
